// File: rtl/inst_loader.sv
// inst_loader: loads a length-prefixed byte stream into instruction memory, holding the core in reset until done.
// Optional trailing XOR checksum byte when INST_LOADER_CHECKSUM_EN is defined.
module inst_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          ADDR_STEP = 4,
    parameter int          MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [31:0] Inst_addr_load,
    output logic [31:0] Inst_load,
    output logic        load_en,
    output logic        cpu_rst_n,
    output logic        busy,
    output logic        done,
    output logic        error
);
    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        WRITE,
        DONE,
`ifdef INST_LOADER_CHECKSUM_EN
        ERROR,
        CHECK
`else
        ERROR
`endif
    } state_t;

    localparam logic [15:0] L_MAX  = 16'(MAX_WORDS);
    localparam logic [31:0] L_STEP = 32'(ADDR_STEP);
`ifdef INST_LOADER_CHECKSUM_EN
    localparam state_t S_FIN = CHECK;
`else
    localparam state_t S_FIN = DONE;
`endif

    state_t      r_state, w_next;
    logic [15:0] r_len, r_idx;
    logic [1:0]  r_bidx;
    logic [31:0] r_word;
    logic        w_xfer, w_start, w_chk;
    logic [15:0] w_len, w_idx_inc;
    logic [31:0] w_word;
`ifdef INST_LOADER_CHECKSUM_EN
    logic [7:0]  r_sum;
    assign w_chk = (w_next == CHECK);
`else
    assign w_chk = 1'b0;
`endif

    assign w_xfer    = byte_valid && byte_ready;
    assign w_start   = start && (r_state == IDLE || r_state == DONE || r_state == ERROR);
    assign w_len     = {byte_in, r_len[7:0]};
    assign w_idx_inc = r_idx + 16'd1;
    assign w_word    = {byte_in, r_word[31:8]};

    always_ff @(posedge clk or posedge rst)
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE, ERROR: if (start) w_next = LEN_LO;
            LEN_LO: if (w_xfer) w_next = LEN_HI;
            LEN_HI: if (w_xfer) begin
                if (w_len == 16'd0)     w_next = S_FIN;
                else if (w_len > L_MAX) w_next = ERROR;
                else                    w_next = DATA;
            end
            DATA: if (w_xfer && r_bidx == 2'd3) w_next = WRITE;
            WRITE: begin
                if (w_idx_inc == r_len) w_next = S_FIN;
                else                    w_next = DATA;
            end
`ifdef INST_LOADER_CHECKSUM_EN
            CHECK: if (w_xfer) begin
                if (byte_in == r_sum) w_next = DONE;
                else                  w_next = ERROR;
            end
`endif
            default: w_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len          <= '0;
            r_idx          <= '0;
            r_bidx         <= '0;
            r_word         <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
            r_sum          <= '0;
`endif
            byte_ready     <= 1'b0;
            Inst_addr_load <= BASE_ADDR;
            Inst_load      <= '0;
            load_en        <= 1'b0;
            cpu_rst_n      <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
        end else begin
            if (w_start) begin
                r_idx  <= '0;
                r_bidx <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
                r_sum  <= '0;
`endif
            end
            if (r_state == LEN_LO && w_xfer) r_len[7:0]  <= byte_in;
            if (r_state == LEN_HI && w_xfer) r_len[15:8] <= byte_in;
            if (r_state == DATA && w_xfer) begin
                r_word <= w_word;
                r_bidx <= r_bidx + 2'd1;
`ifdef INST_LOADER_CHECKSUM_EN
                r_sum  <= r_sum ^ byte_in;
`endif
                if (r_bidx == 2'd3) begin
                    Inst_load      <= w_word;
                    Inst_addr_load <= BASE_ADDR + {16'd0, r_idx} * L_STEP;
                end
            end
            if (r_state == WRITE) r_idx <= w_idx_inc;
            byte_ready <= w_next == LEN_LO || w_next == LEN_HI || w_next == DATA || w_chk;
            load_en    <= w_next == WRITE;
            busy       <= !(w_next == IDLE || w_next == DONE || w_next == ERROR);
            done       <= w_next == DONE;
            error      <= w_next == ERROR;
            cpu_rst_n  <= w_next == DONE;
        end
    end
endmodule

// File: tb/tb_inst_loader.sv
// tb_inst_loader: randomized stream stimulus against a word-list model of the expected memory writes.
module tb_inst_loader;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, byte_valid = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_ready, load_en, cpu_rst_n, busy, done, error;
    logic [31:0] Inst_addr_load, Inst_load;

    typedef logic [7:0]  bq_t[$];
    typedef logic [31:0] wq_t[$];

`ifdef INST_LOADER_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    int tot = 0, bad = 0, viol = 0, cyc = 0;
    logic prev_en = 1'b0;
    logic [63:0] wr[$];

    inst_loader dut (
        .clk(clk), .rst(rst), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .Inst_addr_load(Inst_addr_load), .Inst_load(Inst_load),
        .load_en(load_en), .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Capture every write strobe; a strobe with byte_ready high or two strobes in a row is a violation.
    always @(negedge clk) begin
        if (!rst && load_en) begin
            wr.push_back({Inst_addr_load, Inst_load});
            if (byte_ready || prev_en) viol++;
        end
        prev_en = load_en;
    end

    function automatic bq_t stream(input wq_t w, input int n);
        bq_t s;
        logic [7:0] x = 8'h00;
        s.push_back(n[7:0]);
        s.push_back(n[15:8]);
        foreach (w[i])
            for (int k = 0; k < 4; k++) begin
                s.push_back(8'(w[i] >> (8 * k)));
                x ^= 8'(w[i] >> (8 * k));
            end
        if (CK == 1) s.push_back(x);
        return s;
    endfunction

    function automatic wq_t rand_words(input int n);
        wq_t w;
        for (int i = 0; i < n; i++) w.push_back($urandom);
        return w;
    endfunction

    function automatic wq_t basic_words();
        wq_t w;
        w.push_back(32'h00100513);
        w.push_back(32'h00200593);
        return w;
    endfunction

    task automatic send(input bq_t s, input int mode, input int start_at);
        int t;
        bit acc, ph;
        ph = 1'b0;
        for (int i = 0; i < s.size(); i++) begin
            acc = 1'b0;
            t = 0;
            while (!acc) begin
                byte_in    = s[i];
                byte_valid = (mode == 0) ? 1'b1 : (mode == 1) ? ph : 1'($urandom_range(0, 1));
                ph         = ~ph;
                start      = (i == start_at);
                acc        = byte_valid && byte_ready;
                @(negedge clk);
                if (++t > 200) begin
                    tot++; bad++;
                    $display("FAIL send_timeout byte %0d ready=%b need 1", i, byte_ready);
                    byte_valid = 1'b0; start = 1'b0;
                    return;
                end
            end
        end
        byte_valid = 1'b0;
        start      = 1'b0;
    endtask

    task automatic wait_end(output int c);
        int t = 0;
        while (!(done || error) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        c = cyc;
    endtask

    task automatic test_image(input string name, input wq_t w, input int mode, input int start_at);
        bq_t s;
        int c0, c1, n;
        n = w.size();
        s = stream(w, n);
        wr.delete();
        viol = 0;
        @(negedge clk); start = 1'b1; c0 = cyc;
        @(negedge clk); start = 1'b0;
        send(s, mode, start_at);
        wait_end(c1);
        tot++;
        if ({done, error, cpu_rst_n, busy} !== 4'b1010) begin
            bad++; $display("FAIL %s_status got %b need 1010", name, {done, error, cpu_rst_n, busy});
        end
        tot++;
        if (wr.size() != n) begin
            bad++; $display("FAIL %s_count got %0d need %0d", name, wr.size(), n);
        end else foreach (w[i]) begin
            tot++;
            if (wr[i] !== {32'(i * 4), w[i]}) begin
                bad++; $display("FAIL %s_write%0d got %h need %h", name, i, wr[i], {32'(i * 4), w[i]});
            end
        end
        tot++;
        if (viol != 0) begin
            bad++; $display("FAIL %s_strobe got %0d violations need 0", name, viol);
        end
        tot++;
        if ({Inst_addr_load, Inst_load} !== {32'((n - 1) * 4), w[n - 1]}) begin
            bad++; $display("FAIL %s_hold got %h %h need %h %h", name, Inst_addr_load, Inst_load, 32'((n - 1) * 4), w[n - 1]);
        end
        if (mode == 0) begin
            tot++;
            if (c1 - c0 != 3 + 5 * n + CK) begin
                bad++; $display("FAIL %s_latency got %0d need %0d", name, c1 - c0, 3 + 5 * n + CK);
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tot++;
        if ({byte_ready, Inst_addr_load, Inst_load, load_en, cpu_rst_n, busy, done, error} !== 70'd0) begin
            bad++; $display("FAIL reset got rdy=%b a=%h d=%h en=%b rn=%b b=%b dn=%b er=%b need all 0",
                byte_ready, Inst_addr_load, Inst_load, load_en, cpu_rst_n, busy, done, error);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        test_image("basic", basic_words(), 0, -1);
    endtask

    task automatic test_toggle();
        test_image("toggle", basic_words(), 1, -1);
    endtask

    task automatic test_too_long();
        bq_t s;
        s.push_back(8'h01);
        s.push_back(8'h01);
        wr.delete();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        send(s, 0, -1);
        tot++;
        if ({done, error, cpu_rst_n, busy} !== 4'b0100) begin
            bad++; $display("FAIL too_long_status got %b need 0100", {done, error, cpu_rst_n, busy});
        end
        tot++;
        if (wr.size() != 0) begin
            bad++; $display("FAIL too_long_writes got %0d need 0", wr.size());
        end
        test_image("recover", basic_words(), 2, -1);
    endtask

    task automatic test_zero();
        wq_t w;
        wr.delete();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        send(stream(w, 0), 0, -1);
        tot++;
        if ({done, error, cpu_rst_n, busy} !== 4'b1010 || wr.size() != 0) begin
            bad++; $display("FAIL zero got status %b writes %0d need 1010 and 0", {done, error, cpu_rst_n, busy}, wr.size());
        end
    endtask

    task automatic test_rst_mid();
        bq_t s;
        s = stream(basic_words(), 2);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        send(s[0:7], 0, -1);
        rst = 1'b1;
        #1;
        tot++;
        if ({byte_ready, Inst_addr_load, Inst_load, load_en, cpu_rst_n, busy, done, error} !== 70'd0) begin
            bad++; $display("FAIL rst_mid got rdy=%b a=%h d=%h en=%b rn=%b b=%b dn=%b er=%b need all 0",
                byte_ready, Inst_addr_load, Inst_load, load_en, cpu_rst_n, busy, done, error);
        end
        @(negedge clk); rst = 1'b0;
        test_image("reload", basic_words(), 0, -1);
    endtask

    task automatic test_start_busy();
        test_image("start_busy", rand_words(3), 0, 5);
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) test_image("random", rand_words($urandom_range(1, 6)), 2, -1);
    endtask

    task automatic test_max();
        test_image("max", rand_words(256), 0, -1);
    endtask

`ifdef INST_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        bq_t s;
        int c;
        s = stream(basic_words(), 2);
        s[s.size() - 1] = s[s.size() - 1] ^ 8'h01;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        send(s, 0, -1);
        wait_end(c);
        tot++;
        if ({done, error, cpu_rst_n} !== 3'b010) begin
            bad++; $display("FAIL checksum_bad got %b need 010", {done, error, cpu_rst_n});
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_toggle();
        test_too_long();
        test_zero();
        test_rst_mid();
        test_start_busy();
        test_random();
        test_max();
`ifdef INST_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end
endmodule
